// File: rtl/count_ext_display.sv
// count_ext_display: extends a 4-bit upstream counter with an 8-bit high byte
// and shows the 12-bit result on a 3-digit multiplexed hex 7-segment display.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blanks leading-zero digits D2/D1).
module count_ext_display #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        mr,
  input  logic [3:0]  q_in,
  input  logic        co_in,
  input  logic        hold,
  input  logic        clr_hi,
  output logic [11:0] value,
  output logic        ovf,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned Q_W   = 4;
  localparam int unsigned HI_W  = 8;
  localparam int unsigned VAL_W = Q_W + HI_W;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEG_W = 7;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2
  } scan_state_e;

  logic [Q_W-1:0]   q_q;
  logic             co_q;
  logic [HI_W-1:0]  hi_q,   hi_d;
  logic             ovf_q,  ovf_d;
  logic [VAL_W-1:0] disp_q, disp_d;
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [2:0]       an_q,   an_d;
  logic [SEG_W-1:0] seg_q,  seg_d;

  logic             wrap_c;
  logic [3:0]       digit;
  logic [2:0]       sel;
  logic             blank;

  // Hex digit to active-high {g,f,e,d,c,b,a}
  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] d);
    case (d)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // A wrap is the carry dropping while the counter arrives at zero
  assign wrap_c = co_q & ~co_in & (q_in == 4'h0);

  assign value = {hi_q, q_q};
  assign ovf   = ovf_q;
  assign an    = an_q;
  assign seg   = seg_q;

  // High byte / overflow next state: clr_hi wins over a wrap
  always_comb begin
    hi_d  = hi_q;
    ovf_d = ovf_q;
    if (clr_hi) begin
      hi_d  = '0;
      ovf_d = 1'b0;
    end else if (wrap_c) begin
      hi_d = hi_q + 8'd1;
      if (hi_q == 8'hFF) ovf_d = 1'b1;
    end
  end

  // Display latch follows value unless frozen
  always_comb begin
    disp_d = disp_q;
    if (!hold) disp_d = value;
  end

  // Scan sequencing plus next an/seg, derived from the next slot position
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q + 16'd1;
    an_d    = 3'b111;
    seg_d   = SEG_OFF;
    digit   = disp_q[3:0];
    sel     = 3'b110;
    blank   = 1'b0;

    if (slot_q >= SLOT_LAST) begin
      slot_d = '0;
      case (state_q)
        D0:      state_d = D1;
        D1:      state_d = D2;
        default: state_d = D0;
      endcase
    end

    case (state_d)
      D1: begin
        digit = disp_q[7:4];
        sel   = 3'b101;
`ifdef LEAD_ZERO_BLANK_EN
        blank = (disp_q[11:4] == 8'h00);
`endif
      end
      D2: begin
        digit = disp_q[11:8];
        sel   = 3'b011;
`ifdef LEAD_ZERO_BLANK_EN
        blank = (disp_q[11:8] == 4'h0);
`endif
      end
      default: begin
        digit = disp_q[3:0];
        sel   = 3'b110;
      end
    endcase

    // First cycle of each slot stays dark to avoid ghosting
    if ((slot_d != '0) && !blank) begin
      an_d  = sel;
      seg_d = SEG_ACTIVE_LOW ? ~hex7(digit) : hex7(digit);
    end
  end

  // State registers with synchronous master reset
  always_ff @(posedge clk) begin
    if (mr) begin
      q_q     <= '0;
      co_q    <= 1'b0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      state_q <= D0;
      slot_q  <= '0;
      an_q    <= 3'b111;
      seg_q   <= SEG_OFF;
    end else begin
      q_q     <= q_in;
      co_q    <= co_in;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      state_q <= state_d;
      slot_q  <= slot_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_count_ext_display.sv
// Directed bench for count_ext_display (SCAN_DIV=4, active-low segments).
module tb_count_ext_display;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk;
  logic        mr;
  logic [3:0]  q_in;
  logic        co_in;
  logic        hold;
  logic        clr_hi;
  logic [11:0] value;
  logic        ovf;
  logic [2:0]  an;
  logic [6:0]  seg;

  int n_cmp;
  int n_err;
  int ncyc;

  count_ext_display #(
    .SCAN_DIV       (SCAN_DIV),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .mr     (mr),
    .q_in   (q_in),
    .co_in  (co_in),
    .hold   (hold),
    .clr_hi (clr_hi),
    .value  (value),
    .ovf    (ovf),
    .an     (an),
    .seg    (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges elapsed since the last reset edge; gives the expected scan phase
  always @(posedge clk) begin
    if (mr) ncyc <= 0;
    else    ncyc <= ncyc + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0:    seg_of = 7'h3F;
      4'h1:    seg_of = 7'h06;
      4'h2:    seg_of = 7'h5B;
      4'h3:    seg_of = 7'h4F;
      4'h4:    seg_of = 7'h66;
      4'h5:    seg_of = 7'h6D;
      4'h6:    seg_of = 7'h7D;
      4'h7:    seg_of = 7'h07;
      4'h8:    seg_of = 7'h7F;
      4'h9:    seg_of = 7'h6F;
      4'hA:    seg_of = 7'h77;
      4'hB:    seg_of = 7'h7C;
      4'hC:    seg_of = 7'h39;
      4'hD:    seg_of = 7'h5E;
      4'hE:    seg_of = 7'h79;
      default: seg_of = 7'h71;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream-style E -> F(co) -> 0 sequence; the last edge is a wrap
  task automatic do_wraps(input int n);
    for (int i = 0; i < n; i++) begin
      q_in = 4'hE; co_in = 1'b0; step();
      q_in = 4'hF; co_in = 1'b1; step();
      q_in = 4'h0; co_in = 1'b0; step();
    end
  endtask

  // Compare an/seg against the scan phase for a stable display d2 d1 d0
  task automatic check_scan(input string tag, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0, input int cycles);
    int          pos;
    int          slot;
    logic [2:0]  exp_an;
    logic [6:0]  exp_seg;
    logic [3:0]  dig;
    logic        blk;
    for (int i = 0; i < cycles; i++) begin
      step();
      pos  = ncyc % (3 * SCAN_DIV);
      slot = pos / SCAN_DIV;
      blk  = 1'b0;
      case (slot)
        0:       begin exp_an = 3'b110; dig = d0; end
        1:       begin exp_an = 3'b101; dig = d1;
`ifdef LEAD_ZERO_BLANK_EN
                   blk = ({d2, d1} == 8'h00);
`endif
                 end
        default: begin exp_an = 3'b011; dig = d2;
`ifdef LEAD_ZERO_BLANK_EN
                   blk = (d2 == 4'h0);
`endif
                 end
      endcase
      exp_seg = ~seg_of(dig);
      if ((pos % SCAN_DIV) == 0 || blk) begin
        exp_an  = 3'b111;
        exp_seg = 7'h7F;
      end
      check_eq({tag, "_an"},  16'(an),  16'(exp_an));
      check_eq({tag, "_seg"}, 16'(seg), 16'(exp_seg));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    mr     = 1'b1;
    q_in   = 4'h5;
    co_in  = 1'b0;
    hold   = 1'b0;
    clr_hi = 1'b0;

    // Reset state
    step(); step();
    check_eq("rst_value", 16'(value), 16'h000);
    check_eq("rst_ovf",   16'(ovf),   16'h0);
    check_eq("rst_an",    16'(an),    16'h7);
    check_eq("rst_seg",   16'(seg),   16'h7F);
    mr = 1'b0;
    step();
    check_eq("post_rst_value", 16'(value), 16'h005);
    check_eq("post_rst_an",    16'(an),    16'h6);

    // Three wraps
    do_wraps(3);
    check_eq("wrap3_value", 16'(value), 16'h030);
    check_eq("wrap3_ovf",   16'(ovf),   16'h0);

    // Up to hi=FF, then overflow
    do_wraps(252);
    check_eq("hi_ff_value", 16'(value), 16'hFF0);
    check_eq("hi_ff_ovf",   16'(ovf),   16'h0);
    do_wraps(1);
    check_eq("ovf_value", 16'(value), 16'h000);
    check_eq("ovf_set",   16'(ovf),   16'h1);
    do_wraps(10);
    check_eq("ovf_sticky_value", 16'(value), 16'h0A0);
    check_eq("ovf_sticky",       16'(ovf),   16'h1);
    clr_hi = 1'b1; step(); clr_hi = 1'b0;
    check_eq("clr_ovf", 16'(ovf),   16'h0);
    check_eq("clr_hi",  16'(value), 16'h000);

    // Carry falling onto a non-zero load is not a wrap
    do_wraps(2);
    q_in = 4'hE; co_in = 1'b0; step();
    q_in = 4'hF; co_in = 1'b1; step();
    check_eq("pre_load_value", 16'(value), 16'h02F);
    q_in = 4'h7; co_in = 1'b0; step();
    check_eq("load_no_wrap", 16'(value), 16'h027);

    // clr_hi beats a simultaneous wrap
    q_in = 4'hF; co_in = 1'b1; step();
    q_in = 4'h0; co_in = 1'b0; clr_hi = 1'b1; step(); clr_hi = 1'b0;
    check_eq("clr_wrap_value", 16'(value), 16'h000);
    check_eq("clr_wrap_ovf",   16'(ovf),   16'h0);

    // Scan pattern for 1A3
    do_wraps(26);
    q_in = 4'h3; step(); step(); step();
    check_eq("scan_value", 16'(value), 16'h1A3);
    check_scan("scan_1a3", 4'h1, 4'hA, 4'h3, 24);

    // Master reset mid-operation
    mr = 1'b1; step(); mr = 1'b0;
    check_eq("mr_mid_value", 16'(value), 16'h000);
    check_eq("mr_mid_an",    16'(an),    16'h7);
    check_eq("mr_mid_seg",   16'(seg),   16'h7F);

    // Hold freezes the display while counting goes on
    do_wraps(1);
    q_in = 4'h2; step(); step(); step();
    check_eq("hold_pre_value", 16'(value), 16'h012);
    hold = 1'b1; step();
    do_wraps(2);
    q_in = 4'h2; step();
    check_eq("hold_value", 16'(value), 16'h032);
    check_scan("hold_frozen", 4'h0, 4'h1, 4'h2, 12);
    hold = 1'b0; step(); step();
    check_scan("hold_released", 4'h0, 4'h3, 4'h2, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_ext_display.md
# count_ext_display

- Downstream stage of the 4-bit binary addition counter.
- Consumes the counter's `q`/`co` outputs and detects each 15→0 wrap to advance an 8-bit high-order extension.
- Presents the combined 12-bit count.
- Drives a 3-digit time-multiplexed hexadecimal 7-segment display with an optional display freeze.

## Interface
Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; legal range 2..65535.
- SEG_ACTIVE_LOW, 1: 1 drives segment outputs active-low, 0 active-high.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- mr  input  1  master reset; synchronous and active-high.
- q_in  input  4  counter value from the upstream counter.
- co_in  input  1  carry level from the upstream counter; 1 while the counter holds 4'hF.
- hold  input  1  1 freezes the displayed value; counting continues.
- clr_hi  input  1  synchronous clear of the high byte and of `ovf`.
- value  output  12  {hi[7:0], q_r[3:0]}; reset 12'h000.
- ovf  output  1  sticky flag, set when hi wraps 8'hFF→8'h00; reset 0.
- an  output  3  digit enables, active-low; an[0] is the least significant digit; reset 3'b111.
- seg  output  7  {g,f,e,d,c,b,a}; reset all segments off (7'h7F if SEG_ACTIVE_LOW, else 7'h00).

## Operation
- **Input register**
  - q_in and co_in are registered every cycle into q_r and co_r.
  - `value` is built from the registered copies only.
- **Wrap detect**
  - wrap = co_r==1 and co_in==0 and q_in==4'h0.
  - A co falling edge to any other value (e.g. upstream load) is not a wrap.
- **High byte**
  - On wrap, hi ← hi+1, modulo 256.
  - If hi was 8'hFF, ovf ← 1; ovf stays set until mr or clr_hi.
- **Priority per cycle:** mr > clr_hi > wrap.
  - clr_hi and wrap in the same cycle: hi=0, ovf=0, and the wrap is dropped.
- **Display latch disp[11:0]**
  - Loads `value` every cycle while hold=0.
  - Keeps its contents while hold=1.
- **Scan FSM, states D0→D1→D2→D0**
  - Each state lasts SCAN_DIV cycles, timed by a slot counter.
  - D0 shows disp[3:0], D1 shows disp[7:4], D2 shows disp[11:8].
  - Ghost guard: in the first cycle of every slot, an=3'b111 and all segments are off.
  - For the remaining SCAN_DIV-1 cycles, exactly one `an` bit is low.
- **Hex decode** (active-high form; inverted when SEG_ACTIVE_LOW=1):
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07
  - 8=7'h7F, 9=7'h6F, A=7'h77, b=7'h7C, C=7'h39, d=7'h5E, E=7'h79, F=7'h71.
- **mr mid-operation**
  - Synchronously returns q_r, co_r, hi, ovf, disp, the FSM (to D0) and the slot counter to reset values.
  - Outputs show reset values in the cycle after mr is sampled high.

## Timing
- q_in change → value change: 1 cycle.
- Wrap edge (co_in 1→0 with q_in=0 sampled at edge N) → hi increments at edge N; new value visible after edge N.
- value → disp: 1 cycle while hold=0.
- disp → seg: registered, visible from the next cycle inside the active slot.
- Full scan period: 3×SCAN_DIV cycles; an and seg are registered (glitch-free).
- hold asserted at edge N: disp keeps the value it held after edge N.
- hold released: disp resumes tracking `value` on the next edge.

## Configuration
- LEAD_ZERO_BLANK_EN
  - **Defined:**
    - D2 slot is blanked (an high, segments off) when disp[11:8]==0.
    - D1 slot is blanked when disp[11:4]==0.
    - D0 is never blanked.
    - The scan timing is unchanged.
  - **Undefined:** all three digits are always displayed, including leading zeros.

## Test plan
- mr=1 for 2 cycles, then q_in=4'h5 → value=12'h000 during reset; value=12'h005 one cycle after release; an=3'b111 in the first cycle after reset.
- Drive an upstream-style sequence q_in 4'hE→4'hF (co_in=1)→4'h0 (co_in=0) 3 times → value=12'h030, ovf=0.
- Preload hi=8'hFF via 255 wraps, then one more wrap → hi=8'h00, ovf=1; ovf still 1 after a further 10 wraps; clr_hi → ovf=0, value[11:4]=0.
- co_in falls 1→0 with q_in=4'h7 (upstream load) → hi unchanged; clr_hi and a valid wrap in the same cycle → hi=0.
- SCAN_DIV=4, value=12'h1A3, SEG_ACTIVE_LOW=1 → an cycles 111, 110×3, 111, 101×3, 111, 011×3; seg=~7'h4F, ~7'h77, ~7'h06 in the respective slots.
- hold=1 at value=12'h012, then 2 wraps → value=12'h032, display still shows 0,1,2; hold=0 → display shows 0,3,2 within 2 cycles. With LEAD_ZERO_BLANK_EN defined, the D2 slot is blank in both cases.
